ad9826_cfg_ctrl: RTL
====================

Name: ad9826_cfg_ctrl

Overview:
Serial-port configuration controller for the AD9826 front-end ADC. After reset, or on request, it writes the Config, MUX, Red PGA and Red Offset registers over the 3-wire interface (SCLK/SDATA/SLOAD), reads each one back, and compares it with the value written. It then raises cfg_done, which gates the capture path. It also serialises runtime single-register host accesses and never starts one while a line capture is in progress.

Parameters:
CLK_DIV, 4, SCLK half-period in clk cycles (H); legal range 2..255
CFG_VAL, 9'h0C8, Config register (addr 0) init value
MUX_VAL, 9'h0C0, MUX register (addr 1) init value
RPGA_VAL, 9'h000, Red PGA register (addr 2) init value
ROFS_VAL, 9'h000, Red Offset register (addr 5) init value

Ports:
clk  in  1  system clock
rst_n  in  1  reset
cfg_start  in  1  pulse; re-run the full init sequence
adc_busy  in  1  capture in progress (high from adc_start to adc_done)
host_req  in  1  runtime access request, held until host_ack
host_rw  in  1  1=read, 0=write
host_addr  in  3  register address
host_wdata  in  9  write data
host_ack  out  1  one-cycle pulse when the host access completes
host_rdata  out  9  read data, valid with host_ack
cfg_done  out  1  init sequence passed
cfg_err  out  1  readback mismatch seen in the last init sequence
sclk_o  out  1  serial clock to the ADC
sload_o  out  1  frame select to the ADC, active low
sdata_o  out  1  serial data out
sdata_oe  out  1  sdata pad output enable (1=drive)
sdata_i  in  1  serial data in from the pad

Behaviour:
- Reset: synchronous, active-low rst_n; clock clk. Reset values: sclk_o=0, sload_o=1, sdata_o=0, sdata_oe=1, host_ack=0, host_rdata=0, cfg_done=0, cfg_err=0.
- After reset release, the init sequence starts automatically.
- Reset asserted mid-frame: sload_o goes high and sclk_o goes low on the next clk edge.
- Frame word is 16 bits, MSB first: {rw, addr[2:0], 3'b000, data[8:0]}.
- Frame engine states and durations:
  - IDLE.
  - SETUP, H cycles: sload_o=0, sclk_o=0, bit15 on sdata_o.
  - SHIFT, 16 bits × 2H: for each bit, sclk_o high for H cycles, then low for H cycles; the next bit is presented on the falling edge.
  - END, H cycles: sclk_o=0, sload_o still 0.
  - GAP, 2H cycles: sload_o=1.
  - Then back to IDLE.
  - sload_o is low for exactly 34H cycles; with the default, 136.
- Reads:
  - sdata_oe drops at the falling edge after bit 9 and returns to 1 at the start of END.
  - Bits 8:0 are captured from sdata_i on the clk cycle in which sclk_o rises.
- Sequencer:
  - INIT_WR writes addrs 0, 1, 2, 5.
  - INIT_RD reads addrs 0, 1, 2, 5 and compares each readback with its parameter value.
  - At the end of INIT_RD: cfg_done=1 if every readback matched; otherwise cfg_err=1 and cfg_done=0.
  - The next state is READY.
- cfg_start:
  - Clears cfg_done and cfg_err on the following cycle and re-runs the init sequence.
  - If it arrives mid-frame, the current frame finishes first.
  - Ignored while the init sequence is already running.
- Host access:
  - Accepted only in READY with adc_busy=0, sampled at frame start. adc_busy is checked only before a frame starts; it never aborts a frame in flight.
  - A single frame is issued. host_ack pulses on the last GAP cycle.
  - For a read, host_rdata is updated in the same cycle host_ack pulses; it holds its value until the next read.
  - A host write to addr 0, 1, 2 or 5 updates the stored shadow value that a later cfg_start re-init writes and compares against, replacing the parameter value.
  - host_req during the init sequence is held pending and served after it completes.
  - A request that arrives together with cfg_start loses; the re-init runs first.
- cfg_done stays high through host accesses.

Test Plan:
- Reset release, CLK_DIV=4, sdata_i model echoes registers → 8 frames in order: W0=16'h00C8, W1=16'h10C0, W2=16'h2000, W5=16'h5000, then R0, R1, R2, R5 (e.g. R0=16'h8000); each frame has sload_o low for 136 cycles, and cfg_done=1 after the 8th GAP.
- ADC model returns 9'h0C9 for addr 0 → cfg_err=1, cfg_done=0 after the sequence.
- Host read addr 2 with model value 9'h1A5 → host_rdata=9'h1A5 and a single host_ack pulse.
- host_req (write addr 5, 9'h055) with adc_busy=1 for 500 cycles → no sload_o activity until adc_busy falls; frame 16'h5055 follows, then host_ack.
- Assert rst_n=0 in the middle of bit 7 of a frame → next edge shows sload_o=1, sclk_o=0; the init sequence restarts from W0 after release.
- cfg_start pulse while READY → cfg_done drops the next cycle; 8 frames are re-issued and cfg_done rises again.

Source files
------------

// File: rtl/ad9826_cfg_ctrl_if.sv
// Host access channel for the AD9826 configuration controller.
// The master issues single-register requests; the slave answers with an ack pulse.
interface ad9826_cfg_ctrl_if;
  logic       host_req;
  logic       host_rw;
  logic [2:0] host_addr;
  logic [8:0] host_wdata;
  logic       host_ack;
  logic [8:0] host_rdata;

  modport master (
    output host_req,
    output host_rw,
    output host_addr,
    output host_wdata,
    input  host_ack,
    input  host_rdata
  );

  modport slave (
    input  host_req,
    input  host_rw,
    input  host_addr,
    input  host_wdata,
    output host_ack,
    output host_rdata
  );
endinterface

// File: rtl/ad9826_cfg_ctrl.sv
// AD9826 serial-port configuration controller: writes and verifies the init registers,
// then serialises runtime host accesses over the 3-wire SCLK/SDATA/SLOAD interface.
module ad9826_cfg_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [8:0]  CFG_VAL  = 9'h0C8,
  parameter logic [8:0]  MUX_VAL  = 9'h0C0,
  parameter logic [8:0]  RPGA_VAL = 9'h000,
  parameter logic [8:0]  ROFS_VAL = 9'h000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic               adc_busy,
  ad9826_cfg_ctrl_if.slave   host,
  output logic               cfg_done,
  output logic               cfg_err,
  output logic               sclk_o,
  output logic               sload_o,
  output logic               sdata_o,
  output logic               sdata_oe,
  input  logic               sdata_i
);

  localparam logic [8:0] HLast = 9'(CLK_DIV - 1);
  localparam logic [8:0] GLast = 9'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {FrIdle, FrSetup, FrShift, FrEnd, FrGap} fr_state_e;
  typedef enum logic [1:0] {SqInitWr, SqInitRd, SqReady, SqHost} sq_state_e;

  // Frame engine state
  fr_state_e   fr_q, fr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [3:0]  slot_q, slot_d;
  logic        hi_q, hi_d;
  logic [15:0] word_q, word_d;
  logic [8:0]  rd_sh_q, rd_sh_d;
  logic        sclk_q, sclk_d, sload_q, sload_d, sdata_q, sdata_d, oe_q, oe_d;
  logic        fr_start;
  logic [15:0] fr_word;
  logic        frame_done, frame_last_next;

  // Sequencer state
  sq_state_e       sq_q, sq_d;
  logic [1:0]      idx_q, idx_d;
  logic            err_acc_q, err_acc_d;
  logic            restart_q, restart_d;
  logic            done_q, done_d, err_q, err_d;
  logic            ack_q, ack_d;
  logic [8:0]      rdata_q, rdata_d;
  logic [3:0][8:0] shadow_q, shadow_d;
  logic            h_rw_q, h_rw_d;
  logic [2:0]      h_addr_q, h_addr_d;
  logic [8:0]      h_wdata_q, h_wdata_d;
  logic [2:0]      idx_addr;
  logic            rd_mism, acc_next;

  assign frame_done      = (fr_q == FrGap) && (cnt_q == GLast);
  // Registered host_ack must already be high during the last GAP cycle.
  assign frame_last_next = (fr_q == FrGap) && (cnt_q == GLast - 9'd1);
  assign idx_addr        = (idx_q == 2'd3) ? 3'd5 : {1'b0, idx_q};

  // Frame engine next-state: SETUP, 16 bit slots (high then low phase), END, GAP
  always_comb begin
    fr_d   = fr_q;
    cnt_d  = cnt_q;
    slot_d = slot_q;
    hi_d   = hi_q;
    word_d = word_q;
    case (fr_q)
      FrIdle: begin
        if (fr_start) begin
          fr_d   = FrSetup;
          cnt_d  = '0;
          word_d = fr_word;
        end
      end
      FrSetup: begin
        if (cnt_q == HLast) begin
          fr_d   = FrShift;
          cnt_d  = '0;
          slot_d = '0;
          hi_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      FrShift: begin
        if (cnt_q == HLast) begin
          cnt_d = '0;
          if (hi_q) begin
            hi_d = 1'b0;
          end else if (slot_q == 4'd15) begin
            fr_d = FrEnd;
          end else begin
            slot_d = slot_q + 4'd1;
            hi_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      FrEnd: begin
        if (cnt_q == HLast) begin
          fr_d  = FrGap;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      FrGap: begin
        if (cnt_q == GLast) begin
          fr_d  = FrIdle;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: fr_d = FrIdle;
    endcase
  end

  // Pad outputs decoded from the next engine state so they leave a flop
  always_comb begin
    sload_d = !((fr_d == FrSetup) || (fr_d == FrShift) || (fr_d == FrEnd));
    sclk_d  = (fr_d == FrShift) && hi_d;
    sdata_d = 1'b0;
    if (fr_d == FrSetup) begin
      sdata_d = word_d[15];
    end else if (fr_d == FrShift) begin
      if (hi_d) begin
        sdata_d = word_d[4'd15 - slot_d];
      end else if (slot_d != 4'd15) begin
        sdata_d = word_d[4'd14 - slot_d];
      end
    end
    // Read frames release the pad from the falling edge after bit 9 until END
    oe_d = !((fr_d == FrShift) && word_d[15] &&
             ((slot_d > 4'd6) || ((slot_d == 4'd6) && !hi_d)));
    rd_sh_d = rd_sh_q;
    if (sclk_d && !sclk_q && word_d[15] && (slot_d >= 4'd7)) begin
      rd_sh_d = {rd_sh_q[7:0], sdata_i};
    end
  end

  // Frame engine registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fr_q    <= FrIdle;
      cnt_q   <= '0;
      slot_q  <= '0;
      hi_q    <= 1'b0;
      word_q  <= '0;
      rd_sh_q <= '0;
      sclk_q  <= 1'b0;
      sload_q <= 1'b1;
      sdata_q <= 1'b0;
      oe_q    <= 1'b1;
    end else begin
      fr_q    <= fr_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      hi_q    <= hi_d;
      word_q  <= word_d;
      rd_sh_q <= rd_sh_d;
      sclk_q  <= sclk_d;
      sload_q <= sload_d;
      sdata_q <= sdata_d;
      oe_q    <= oe_d;
    end
  end

  // Sequencer next-state: init write/readback, then host service
  always_comb begin
    sq_d      = sq_q;
    idx_d     = idx_q;
    err_acc_d = err_acc_q;
    restart_d = restart_q;
    done_d    = done_q;
    err_d     = err_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    shadow_d  = shadow_q;
    h_rw_d    = h_rw_q;
    h_addr_d  = h_addr_q;
    h_wdata_d = h_wdata_q;
    fr_start  = 1'b0;
    fr_word   = '0;
    rd_mism   = (rd_sh_q != shadow_q[idx_q]);
    acc_next  = err_acc_q | rd_mism;
    case (sq_q)
      SqInitWr: begin
        fr_start = 1'b1;
        fr_word  = {1'b0, idx_addr, 3'b000, shadow_q[idx_q]};
        if (frame_done) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) sq_d = SqInitRd;
        end
      end
      SqInitRd: begin
        fr_start = 1'b1;
        fr_word  = {1'b1, idx_addr, 12'h000};
        if (frame_done) begin
          err_acc_d = acc_next;
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            sq_d   = SqReady;
            done_d = !acc_next;
            err_d  = acc_next;
          end
        end
      end
      SqReady: begin
        // A re-init request beats a host request arriving in the same cycle
        if (cfg_start) begin
          sq_d      = SqInitWr;
          idx_d     = '0;
          err_acc_d = 1'b0;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end else if (host.host_req && !adc_busy && (fr_q == FrIdle)) begin
          fr_start  = 1'b1;
          fr_word   = {host.host_rw, host.host_addr, 3'b000,
                       host.host_rw ? 9'h000 : host.host_wdata};
          h_rw_d    = host.host_rw;
          h_addr_d  = host.host_addr;
          h_wdata_d = host.host_wdata;
          sq_d      = SqHost;
        end
      end
      SqHost: begin
        if (cfg_start) begin
          restart_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
        if (frame_last_next) begin
          ack_d = 1'b1;
          if (h_rw_q) begin
            rdata_d = rd_sh_q;
          end else begin
            case (h_addr_q)
              3'd0:    shadow_d[0] = h_wdata_q;
              3'd1:    shadow_d[1] = h_wdata_q;
              3'd2:    shadow_d[2] = h_wdata_q;
              3'd5:    shadow_d[3] = h_wdata_q;
              default: ;
            endcase
          end
        end
        if (frame_done) begin
          if (restart_q || cfg_start) begin
            sq_d      = SqInitWr;
            idx_d     = '0;
            err_acc_d = 1'b0;
            restart_d = 1'b0;
          end else begin
            sq_d = SqReady;
          end
        end
      end
      default: sq_d = SqInitWr;
    endcase
  end

  // Sequencer registers; reset restarts init with the parameter values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq_q      <= SqInitWr;
      idx_q     <= '0;
      err_acc_q <= 1'b0;
      restart_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      shadow_q  <= {ROFS_VAL, RPGA_VAL, MUX_VAL, CFG_VAL};
      h_rw_q    <= 1'b0;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
    end else begin
      sq_q      <= sq_d;
      idx_q     <= idx_d;
      err_acc_q <= err_acc_d;
      restart_q <= restart_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      shadow_q  <= shadow_d;
      h_rw_q    <= h_rw_d;
      h_addr_q  <= h_addr_d;
      h_wdata_q <= h_wdata_d;
    end
  end

  assign host.host_ack   = ack_q;
  assign host.host_rdata = rdata_q;
  assign cfg_done        = done_q;
  assign cfg_err         = err_q;
  assign sclk_o          = sclk_q;
  assign sload_o         = sload_q;
  assign sdata_o         = sdata_q;
  assign sdata_oe        = oe_q;

endmodule
